// File: rtl/uart_tx_feeder_if.sv
// Write-side FIFO bus and UART transmitter handshake for uart_tx_feeder.
// The slave modport is the feeder; the master modport is whatever drives it.
interface uart_tx_feeder_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                wr_en;
    logic [7:0]          wr_data;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;
    logic                clr_ovf;
    logic                tx_busy;
    logic [7:0]          tx_data;
    logic                tx_pluse;
    logic                idle;

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_busy,
        output full, empty, level, overflow, tx_data, tx_pluse, idle
    );

    modport master (
        output wr_en, wr_data, clr_ovf, tx_busy,
        input  full, empty, level, overflow, tx_data, tx_pluse, idle
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that drains one byte at a time into a UART transmitter, with a
// start-request handshake, an acknowledge timeout with retry, and a guard gap.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_feeder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RETRY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [LVL_W-1:0]      level;
    logic                  overflow;
    logic [CNT_W-1:0]      ack_cnt;
    logic [7:0]            tx_data;
    logic                  tx_pluse;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign pop   = (state == S_LOAD) && !empty;
    // A write into a full FIFO still fits when the head leaves on the same edge.
    assign push  = bus.wr_en && (!full || pop);
    assign drop  = bus.wr_en && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                // tx_busy guard also covers a frame left running across a reset.
                if (!empty && !bus.tx_busy) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: state_next = S_START;
            S_START: begin
                if (bus.tx_busy) begin
                    state_next = S_WAIT_DONE;
                end else if (ack_cnt == CNT_LAST) begin
                    state_next = S_RETRY;
                end
            end
            S_RETRY: state_next = S_START;
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = S_GAP;
                end
            end
            S_GAP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ack_cnt  <= '0;
            tx_pluse <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_next;
            ack_cnt  <= (state == S_START) ? ack_cnt + 1'b1 : '0;
            tx_pluse <= (state_next == S_START);
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign bus.overflow = overflow;
    assign bus.tx_data  = tx_data;
    assign bus.tx_pluse = tx_pluse;
    assign bus.idle     = empty && (state == S_IDLE) && !bus.tx_busy;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a 4-clock-per-bit transmitter model drives a serial
// line, a line receiver decodes it, and decoded bytes are compared to a queue.
module tb_uart_tx_feeder;
    localparam int DEPTH_LOG2 = 4;
    localparam int BPS_NUM    = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] expq[$];
    logic [7:0] rxq[$];

    logic force_busy = 1'b0;
    logic gap_en     = 1'b0;
    logic hold_en    = 1'b1;
    int   ign_req    = 0;

    uart_tx_feeder_if #(.DEPTH_LOG2(DEPTH_LOG2)) ifc ();

    uart_tx_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .ACK_TIMEOUT(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter model: no reset, starts a frame one clock after seeing a rising
    // tx_pluse, optionally ignoring one request when asked.
    logic       busy_m    = 1'b0;
    logic       line_m    = 1'b1;
    logic       pl_q      = 1'b0;
    int         ign_done  = 0;
    logic [9:0] frame_m   = '1;
    logic [7:0] tx_byte   = '0;
    int         tx_c      = 0;
    int         hold_err  = 0;

    assign ifc.tx_busy = busy_m | force_busy;

    always @(posedge clk) begin
        pl_q <= ifc.tx_pluse;
        if (!busy_m) begin
            if (ifc.tx_pluse && !pl_q) begin
                if (ign_req != ign_done) begin
                    ign_done <= ign_done + 1;
                end else begin
                    busy_m   <= 1'b1;
                    line_m   <= 1'b0;
                    frame_m  <= {1'b1, ifc.tx_data, 1'b0};
                    tx_byte  <= ifc.tx_data;
                    tx_c     <= 1;
                    hold_err <= 0;
                end
            end
        end else begin
            if (ifc.tx_data !== tx_byte) hold_err <= hold_err + 1;
            if (tx_c == 10 * BPS_NUM) begin
                busy_m <= 1'b0;
                line_m <= 1'b1;
                if (hold_en) check_eq("tx_data_hold_errors", hold_err, 0);
            end else begin
                line_m <= frame_m[tx_c / BPS_NUM];
            end
            tx_c <= tx_c + 1;
        end
    end

    // Line receiver: samples mid-bit, LSB first.
    logic       rx_act = 1'b0;
    int         rx_v   = 0;
    logic [7:0] rx_sh  = '0;

    always @(posedge clk) begin
        if (!rx_act) begin
            if (!line_m) begin
                rx_act <= 1'b1;
                rx_v   <= 2;
            end
        end else begin
            rx_v <= rx_v + 1;
            if (rx_v == 2) begin
                check_eq("rx_start_bit", line_m, 0);
            end else if (rx_v == 38) begin
                check_eq("rx_stop_bit", line_m, 1);
                rxq.push_back(rx_sh);
                rx_act <= 1'b0;
            end else if (rx_v % 4 == 2) begin
                rx_sh <= {line_m, rx_sh[7:1]};
            end
        end
    end

    // Spacing between the end of one frame and the next start request.
    int   cyc       = 0;
    int   last_fall = -100;
    logic bz_q      = 1'b0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        bz_q <= ifc.tx_busy;
        if (bz_q && !ifc.tx_busy) last_fall <= cyc;
        if (gap_en && ifc.tx_pluse && !pl_q) check_eq("pulse_gap_ge2", (cyc - last_fall >= 2), 1);
    end

    task automatic write_byte(input logic [7:0] d);
        ifc.wr_en   = 1'b1;
        ifc.wr_data = d;
        @(negedge clk);
        ifc.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (!ifc.idle && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", ifc.idle, 1);
    endtask

    task automatic compare_rx(input string tag);
        check_eq({tag, "_count"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) check_eq(tag, rxq[i], expq[i]);
        rxq.delete();
        expq.delete();
    endtask

    initial begin
        int n;
        int hi;
        int lo;
        int peak;
        logic [7:0] d;

        rst_n       = 1'b0;
        ifc.wr_en   = 1'b0;
        ifc.wr_data = 8'h00;
        ifc.clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_pluse", ifc.tx_pluse, 0);
        check_eq("rst_tx_data", ifc.tx_data, 8'h00);
        check_eq("rst_level", ifc.level, 0);
        check_eq("rst_empty", ifc.empty, 1);
        check_eq("rst_full", ifc.full, 0);
        check_eq("rst_overflow", ifc.overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_idle", ifc.idle, 1);

        // Single byte latency and frame
        ifc.wr_en = 1'b1;
        ifc.wr_data = 8'hA5;
        expq.push_back(8'hA5);
        @(negedge clk);
        ifc.wr_en = 1'b0;
        check_eq("lat_edge_k", ifc.tx_pluse, 0);
        @(negedge clk);
        check_eq("lat_edge_k1", ifc.tx_pluse, 0);
        @(negedge clk);
        check_eq("lat_edge_k2_pluse", ifc.tx_pluse, 1);
        check_eq("lat_edge_k2_data", ifc.tx_data, 8'hA5);
        wait_idle(200);
        compare_rx("single");

        // Burst of 16
        gap_en = 1'b1;
        peak = 0;
        for (int i = 1; i <= 16; i++) begin
            expq.push_back(8'(i));
            write_byte(8'(i));
            if (int'(ifc.level) > peak) peak = int'(ifc.level);
        end
        check_eq("burst_peak_15_16", (peak == 15 || peak == 16), 1);
        check_eq("burst_no_overflow", ifc.overflow, 0);
        wait_idle(1200);
        compare_rx("burst");
        gap_en = 1'b0;

        // Overflow with transmitter held busy
        force_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expq.push_back(8'h20 + 8'(i));
            write_byte(8'h20 + 8'(i));
            if (i == 15) begin
                check_eq("ovf_full_at16", ifc.full, 1);
                check_eq("ovf_level_at16", ifc.level, 16);
                check_eq("ovf_clear_at16", ifc.overflow, 0);
            end
        end
        check_eq("ovf_set_at17", ifc.overflow, 1);
        check_eq("ovf_level_at17", ifc.level, 16);
        ifc.clr_ovf = 1'b1;
        @(negedge clk);
        ifc.clr_ovf = 1'b0;
        check_eq("ovf_cleared", ifc.overflow, 0);
        ifc.clr_ovf = 1'b1;
        write_byte(8'h3F);
        ifc.clr_ovf = 1'b0;
        check_eq("ovf_set_wins", ifc.overflow, 1);
        ifc.clr_ovf = 1'b1;
        @(negedge clk);
        ifc.clr_ovf = 1'b0;
        check_eq("ovf_cleared2", ifc.overflow, 0);

        // Release busy and write on the pop cycle
        force_busy = 1'b0;
        @(negedge clk);
        check_eq("pop_pre_level", ifc.level, 16);
        expq.push_back(8'h31);
        write_byte(8'h31);
        check_eq("pop_write_level", ifc.level, 16);
        check_eq("pop_write_no_ovf", ifc.overflow, 0);
        wait_idle(1400);
        compare_rx("full_pop");

        // Ignored start request, retry
        ign_req++;
        expq.push_back(8'h5A);
        write_byte(8'h5A);
        n = 0;
        while (!ifc.tx_pluse && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("retry_first_data", ifc.tx_data, 8'h5A);
        hi = 0;
        while (ifc.tx_pluse && hi < 40) begin
            @(negedge clk);
            hi++;
        end
        check_eq("retry_high_cycles", hi, 8);
        lo = 0;
        while (!ifc.tx_pluse && lo < 10) begin
            @(negedge clk);
            lo++;
        end
        check_eq("retry_low_cycles", lo, 1);
        check_eq("retry_same_data", ifc.tx_data, 8'h5A);
        wait_idle(200);
        compare_rx("retry");

        // Randomized bursts
        gap_en = 1'b1;
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                expq.push_back(d);
                write_byte(d);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(700);
            check_eq("rand_no_overflow", ifc.overflow, 0);
        end
        compare_rx("random");
        gap_en = 1'b0;

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) write_byte(8'h61 + 8'(i));
        expq.push_back(8'h61);
        n = 0;
        while (!(busy_m && !ifc.tx_pluse) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("midrst_level_before", ifc.level, 3);
        hold_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_tx_pluse", ifc.tx_pluse, 0);
        check_eq("midrst_tx_data", ifc.tx_data, 8'h00);
        check_eq("midrst_level", ifc.level, 0);
        check_eq("midrst_empty", ifc.empty, 1);
        check_eq("midrst_full", ifc.full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        expq.push_back(8'h70);
        write_byte(8'h70);
        hi = 0;
        n = 0;
        while (busy_m && n < 60) begin
            if (ifc.tx_pluse) hi++;
            @(negedge clk);
            n++;
        end
        check_eq("midrst_no_pulse_while_busy", hi, 0);
        hold_en = 1'b1;
        wait_idle(200);
        compare_rx("midrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
